// File: rtl/except_ctrl_if.sv
// Redirect handshake between the exception controller and the fetch unit.
// The master drives the new fetch PC; the slave (fetch) returns ready.
interface except_ctrl_if;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;

  modport master (
    output redirect_valid_o,
    output redirect_pc_o,
    input  redirect_ready_i
  );

  modport slave (
    input  redirect_valid_o,
    input  redirect_pc_o,
    output redirect_ready_i
  );
endinterface

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: picks one exception code for CP0, flushes the
// pipeline for a fixed number of cycles, then hands the new fetch PC to fetch.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [31:0]          pc_i,
  input  logic                 is_in_delayslot_i,
  input  logic                 fetch_adel_i,
  input  logic                 ri_i,
  input  logic                 syscall_i,
  input  logic                 break_i,
  input  logic                 eret_i,
  input  logic                 trap_i,
  input  logic                 ov_i,
  input  logic                 load_adel_i,
  input  logic                 store_ades_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          cp0_status_i,
  input  logic [31:0]          cp0_cause_i,
  input  logic [31:0]          cp0_epc_i,
  input  logic                 wb_cp0_we_i,
  input  logic [4:0]           wb_cp0_waddr_i,
  input  logic [31:0]          wb_cp0_data_i,
  output logic [31:0]          except_type_o,
  output logic [31:0]          pc_o,
  output logic                 is_in_delayslot_o,
  output logic [31:0]          mem_addr_o,
  output logic                 flush_o,
  except_ctrl_if.master        redir,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] target_reg, target_next;

  logic [31:0] status_e, cause_e, epc_e;
  logic        int_pending;
  logic [7:0]  code;
  logic        unused_bits;

  // A CP0 write sitting in WB must be seen now, not one cycle late.
  always_comb begin
    status_e = cp0_status_i;
    cause_e  = cp0_cause_i;
    epc_e    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == 5'd12) status_e = wb_cp0_data_i;
      if (wb_cp0_waddr_i == 5'd13) cause_e[9:8] = wb_cp0_data_i[9:8];
      if (wb_cp0_waddr_i == 5'd14) epc_e = wb_cp0_data_i;
    end
  end

  assign unused_bits = ^{status_e[31:16], status_e[7:2], cause_e[31:16], cause_e[7:0]};

  assign int_pending = valid_i && status_e[0] && !status_e[1] &&
                       ((cause_e[15:8] & status_e[15:8]) != 8'h00);

  always_comb begin
    code = 8'h00;
    if (valid_i) begin
      if (int_pending)       code = 8'h01;
      else if (fetch_adel_i) code = 8'h0f;
      else if (ri_i)         code = 8'h0a;
      else if (syscall_i)    code = 8'h08;
      else if (break_i)      code = 8'h09;
      else if (eret_i)       code = 8'h0e;
      else if (trap_i)       code = 8'h0d;
      else if (ov_i)         code = 8'h0c;
      else if (load_adel_i)  code = 8'h04;
      else if (store_ades_i) code = 8'h05;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      target_reg <= 32'h0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      target_reg <= target_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    target_next = target_reg;
    case (state_reg)
      IDLE: begin
        if (code != 8'h00) begin
          state_next  = FLUSH;
          cnt_next    = FLUSH_CYCLES[3:0];
          target_next = (code == 8'h0e) ? epc_e : EXC_VECTOR;
        end
      end
      FLUSH: begin
        if (cnt_reg <= 4'd1) begin
          state_next = REDIRECT;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      REDIRECT: begin
        if (redir.redirect_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flags arriving while flushing/redirecting belong to squashed instructions.
  always_comb begin
    except_type_o          = 32'h0;
    flush_o                = 1'b0;
    redir.redirect_valid_o = 1'b0;
    busy_o                 = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (!rst) begin
          except_type_o = {24'h0, code};
          flush_o       = (code != 8'h00);
        end
      end
      FLUSH:    flush_o = 1'b1;
      REDIRECT: redir.redirect_valid_o = 1'b1;
      default:  flush_o = 1'b0;
    endcase
  end

  assign redir.redirect_pc_o = target_reg;
  assign pc_o                = pc_i;
  assign is_in_delayslot_o   = is_in_delayslot_i;
  assign mem_addr_o          = mem_addr_i;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: a cycle-level reference model checked on every
// negedge, plus literal expectations at the key points of each scenario.
module tb_except_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i;
  logic        fetch_adel_i, ri_i, syscall_i, break_i, eret_i, trap_i, ov_i, load_adel_i, store_ades_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] except_type_o, pc_o, mem_addr_o;
  logic        is_in_delayslot_o, flush_o, busy_o;

  except_ctrl_if rif ();

  except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i),
    .fetch_adel_i(fetch_adel_i), .ri_i(ri_i), .syscall_i(syscall_i), .break_i(break_i),
    .eret_i(eret_i), .trap_i(trap_i), .ov_i(ov_i), .load_adel_i(load_adel_i),
    .store_ades_i(store_ades_i), .mem_addr_i(mem_addr_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .except_type_o(except_type_o), .pc_o(pc_o), .is_in_delayslot_o(is_in_delayslot_o),
    .mem_addr_o(mem_addr_o), .flush_o(flush_o), .redir(rif), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the exception code from the architectural rules, as a priority table.
  function automatic logic [7:0] model_code();
    logic [31:0] st, ca;
    logic        f [10];
    logic [7:0]  c [10];
    st = cp0_status_i;
    ca = cp0_cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];
    f[0] = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 0); c[0] = 8'h01;
    f[1] = fetch_adel_i; c[1] = 8'h0f;
    f[2] = ri_i;         c[2] = 8'h0a;
    f[3] = syscall_i;    c[3] = 8'h08;
    f[4] = break_i;      c[4] = 8'h09;
    f[5] = eret_i;       c[5] = 8'h0e;
    f[6] = trap_i;       c[6] = 8'h0d;
    f[7] = ov_i;         c[7] = 8'h0c;
    f[8] = load_adel_i;  c[8] = 8'h04;
    f[9] = store_ades_i; c[9] = 8'h05;
    if (!valid_i) return 8'h00;
    for (int i = 0; i < 10; i++) if (f[i]) return c[i];
    return 8'h00;
  endfunction

  function automatic logic [31:0] model_epc();
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) return wb_cp0_data_i;
    return cp0_epc_i;
  endfunction

  // Model timeline: flush cycles left after detection, then a pending redirect.
  int          m_left   = 0;
  logic        m_redir  = 1'b0;
  logic [31:0] m_target = 32'h0;

  initial begin
    logic [7:0] code;
    logic       idle;
    forever begin
      @(negedge clk);
      code = model_code();
      idle = (m_left == 0) && !m_redir;
      chk("except_type", except_type_o, (idle && !rst) ? {24'h0, code} : 32'h0);
      chk("flush", {31'h0, flush_o}, {31'h0, idle ? (!rst && code != 0) : (m_left > 0)});
      chk("redirect_valid", {31'h0, rif.redirect_valid_o}, {31'h0, m_redir});
      chk("redirect_pc", rif.redirect_pc_o, m_target);
      chk("busy", {31'h0, busy_o}, {31'h0, !idle});
      chk("pc_pass", pc_o, pc_i);
      chk("addr_pass", mem_addr_o, mem_addr_i);
      chk("ds_pass", {31'h0, is_in_delayslot_o}, {31'h0, is_in_delayslot_i});
      if (rst) begin
        m_left = 0; m_redir = 1'b0; m_target = 32'h0;
      end else if (idle && code != 0) begin
        m_left   = FC;
        m_target = (code == 8'h0e) ? model_epc() : VEC;
      end else if (m_left > 0) begin
        if (m_left == 1) m_redir = 1'b1;
        m_left--;
      end else if (m_redir && rif.redirect_ready_i) begin
        m_redir = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    valid_i = 0; is_in_delayslot_i = 0; pc_i = 32'h0; mem_addr_i = 32'h0;
    fetch_adel_i = 0; ri_i = 0; syscall_i = 0; break_i = 0; eret_i = 0;
    trap_i = 0; ov_i = 0; load_adel_i = 0; store_ades_i = 0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
  endtask

  // Leave the detect cycle and run the flow back to IDLE with ready high.
  task automatic finish_flow();
    step();
    clear();
    rif.redirect_ready_i = 1'b1;
    repeat (3) step();
    #2 chk("lit_idle_after", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear();
    rif.redirect_ready_i = 1'b1;
    rst = 1'b1;
    step(); step();
    #2 chk("lit_reset_pc", rif.redirect_pc_o, 32'h0);
    rst = 1'b0;
    step();

    // Syscall flow
    pc_i = 32'hBFC00100; valid_i = 1; syscall_i = 1;
    #2 chk("lit_sys_type", except_type_o, 32'h08);
    chk("lit_sys_flush0", {31'h0, flush_o}, 32'h1);
    step(); clear();
    #2 chk("lit_sys_flush1", {31'h0, flush_o}, 32'h1);
    chk("lit_sys_type_masked", except_type_o, 32'h0);
    step();
    #2 chk("lit_sys_flush2", {31'h0, flush_o}, 32'h1);
    step();
    #2 chk("lit_sys_flush3", {31'h0, flush_o}, 32'h0);
    chk("lit_sys_rvalid", {31'h0, rif.redirect_valid_o}, 32'h1);
    chk("lit_sys_rpc", rif.redirect_pc_o, VEC);
    step();
    #2 chk("lit_sys_busy", {31'h0, busy_o}, 32'h0);
    chk("lit_sys_rvalid_off", {31'h0, rif.redirect_valid_o}, 32'h0);

    // ERET with EPC bypass from WB
    step();
    valid_i = 1; eret_i = 1; cp0_epc_i = 32'h80001234;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h80005678;
    #2 chk("lit_eret_type", except_type_o, 32'h0e);
    step(); clear(); step(); step();
    #2 chk("lit_eret_rpc", rif.redirect_pc_o, 32'h80005678);
    step(); step();

    // Interrupt gating
    valid_i = 1; ri_i = 1; cp0_status_i = 32'h00000401; cp0_cause_i = 32'h00000400;
    #2 chk("lit_int_type", except_type_o, 32'h01);
    finish_flow(); step();
    valid_i = 1; ri_i = 1; cp0_status_i = 32'h00000403; cp0_cause_i = 32'h00000400;
    #2 chk("lit_int_exl", except_type_o, 32'h0a);
    finish_flow(); step();
    valid_i = 1; ri_i = 1; cp0_status_i = 32'h00000401; cp0_cause_i = 32'h00000400;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h00000400;
    #2 chk("lit_int_wb_ie0", except_type_o, 32'h0a);
    finish_flow(); step();
    valid_i = 1; cp0_status_i = 32'h00000101;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h00000100;
    #2 chk("lit_int_sw_bypass", except_type_o, 32'h01);
    finish_flow(); step();

    // Priority and valid gating
    valid_i = 1; ov_i = 1; load_adel_i = 1; store_ades_i = 1; mem_addr_i = 32'h1003;
    #2 chk("lit_pri_type", except_type_o, 32'h0c);
    chk("lit_pri_addr", mem_addr_o, 32'h1003);
    finish_flow(); step();
    fetch_adel_i = 1; ri_i = 1; syscall_i = 1; break_i = 1; eret_i = 1; trap_i = 1;
    ov_i = 1; load_adel_i = 1; store_ades_i = 1; valid_i = 0;
    #2 chk("lit_novalid_type", except_type_o, 32'h0);
    chk("lit_novalid_flush", {31'h0, flush_o}, 32'h0);
    step();
    valid_i = 1; ov_i = 0; store_ades_i = 0; fetch_adel_i = 0; ri_i = 0; syscall_i = 0;
    break_i = 0; eret_i = 0; trap_i = 0;
    #2 chk("lit_load_adel", except_type_o, 32'h04);
    finish_flow(); step();

    // Backpressure with trap pulsing
    rif.redirect_ready_i = 1'b0;
    valid_i = 1; trap_i = 1;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      trap_i = i[0];
      #2 chk("lit_bp_rvalid", {31'h0, rif.redirect_valid_o}, 32'h1);
      chk("lit_bp_rpc", rif.redirect_pc_o, VEC);
      chk("lit_bp_type", except_type_o, 32'h0);
      step();
    end
    clear();
    rif.redirect_ready_i = 1'b1;
    step();
    #2 chk("lit_bp_idle", {31'h0, busy_o}, 32'h0);
    step();

    // Reset during the second FLUSH cycle
    valid_i = 1; syscall_i = 1;
    step(); clear(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2 chk("lit_rst_flush", {31'h0, flush_o}, 32'h0);
    chk("lit_rst_rvalid", {31'h0, rif.redirect_valid_o}, 32'h0);
    chk("lit_rst_busy", {31'h0, busy_o}, 32'h0);
    chk("lit_rst_rpc", rif.redirect_pc_o, 32'h0);
    step();
    valid_i = 1; break_i = 1;
    #2 chk("lit_rst_break", except_type_o, 32'h09);
    finish_flow();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
